// File: rtl/stream_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_capture : arm, capture one N_DATA frame from a data_source stream,
//                  flag framing problems, then play the frame back on rd_en.
// Revision       : 1.0
// ---------------------------------------------------------------------------
module stream_capture #(
  parameter int WIDTH    = 32,
  parameter int MWIDTH   = 1,
  parameter int N_DATA   = 16,
  parameter int LOGNDATA = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                in_nd,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [MWIDTH-1:0]   in_m,
  input  logic                in_first,
  input  logic                in_error,
  input  logic                rd_en,
  output logic [WIDTH-1:0]    rd_data,
  output logic [MWIDTH-1:0]   rd_m,
  output logic                rd_valid,
  output logic                rd_last,
  output logic                done,
  output logic [LOGNDATA:0]   count,
  output logic                sync_error,
  output logic                overflow,
  output logic                up_error
);

  localparam int WORD_W = WIDTH + MWIDTH;
  localparam logic [LOGNDATA:0]   c_full_count = (LOGNDATA+1)'(N_DATA);
  localparam logic [LOGNDATA-1:0] c_last_addr  = LOGNDATA'(N_DATA - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_FULL    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [LOGNDATA:0]   count_q, count_d;
  logic [LOGNDATA-1:0] rd_addr_q, rd_addr_d;
  logic                done_q, done_d;
  logic                sync_error_q, sync_error_d;
  logic                overflow_q, overflow_d;
  logic                up_error_q, up_error_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q, rd_last_d;
  logic                mem_we;
  logic                rd_fire;
  logic [WORD_W-1:0]   rd_word_q;
  logic [WORD_W-1:0]   mem [N_DATA];

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rd_addr_d    = rd_addr_q;
    done_d       = done_q;
    sync_error_d = sync_error_q;
    overflow_d   = overflow_q;
    up_error_d   = up_error_q;
    rd_valid_d   = 1'b0;
    rd_last_d    = 1'b0;
    mem_we       = 1'b0;
    rd_fire      = 1'b0;

    if (arm) begin
      state_d      = S_ARMED;
      count_d      = '0;
      rd_addr_d    = '0;
      done_d       = 1'b0;
      sync_error_d = 1'b0;
      overflow_d   = 1'b0;
      up_error_d   = 1'b0;
    end else begin
      if (state_q != S_IDLE && in_error) up_error_d = 1'b1;
      case (state_q)
        S_ARMED: begin
          // Samples ahead of the first-flagged one are silently dropped
          if (in_nd && in_first) begin
            mem_we  = 1'b1;
            count_d = count_q + 1'b1;
            if (count_d == c_full_count) begin
              state_d = S_FULL;
              done_d  = 1'b1;
            end else begin
              state_d = S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (in_nd) begin
            mem_we  = 1'b1;
            count_d = count_q + 1'b1;
            if (in_first) sync_error_d = 1'b1;
            if (count_d == c_full_count) begin
              state_d = S_FULL;
              done_d  = 1'b1;
            end
          end
        end
        S_FULL: begin
          if (in_nd) overflow_d = 1'b1;
          if (rd_en) begin
            rd_fire    = 1'b1;
            rd_valid_d = 1'b1;
            rd_addr_d  = rd_addr_q + 1'b1;
            if (rd_addr_q == c_last_addr) begin
              rd_last_d = 1'b1;
              rd_addr_d = '0;
              state_d   = S_IDLE;
              done_d    = 1'b0;
              count_d   = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      rd_addr_q    <= '0;
      done_q       <= 1'b0;
      sync_error_q <= 1'b0;
      overflow_q   <= 1'b0;
      up_error_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_addr_q    <= rd_addr_d;
      done_q       <= done_d;
      sync_error_q <= sync_error_d;
      overflow_q   <= overflow_d;
      up_error_q   <= up_error_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
    end
  end

  // Contents are never reset so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (mem_we) mem[count_q[LOGNDATA-1:0]] <= {in_m, in_data};
  end

  always_ff @(posedge clk) begin
    if (rst)          rd_word_q <= '0;
    else if (rd_fire) rd_word_q <= mem[rd_addr_q];
  end

  assign rd_data    = rd_word_q[WIDTH-1:0];
  assign rd_m       = rd_word_q[WORD_W-1:WIDTH];
  assign rd_valid   = rd_valid_q;
  assign rd_last    = rd_last_q;
  assign done       = done_q;
  assign count      = count_q;
  assign sync_error = sync_error_q;
  assign overflow   = overflow_q;
  assign up_error   = up_error_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_stream_capture : directed + random stimulus against a queue-based model,
//                     plus a small directed run of an N_DATA=1 instance.
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_stream_capture;

  localparam int W  = 32;
  localparam int MW = 1;
  localparam int N  = 16;
  localparam int LN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (N_DATA=16)
  logic          rst, arm, in_nd, in_first, in_error, rd_en;
  logic [W-1:0]  in_data;
  logic [MW-1:0] in_m;
  logic [W-1:0]  rd_data;
  logic [MW-1:0] rd_m;
  logic          rd_valid, rd_last, done, sync_error, overflow, up_error;
  logic [LN:0]   count;

  stream_capture #(.WIDTH(W), .MWIDTH(MW), .N_DATA(N), .LOGNDATA(LN)) dut (
    .clk(clk), .rst(rst), .arm(arm), .in_nd(in_nd), .in_data(in_data),
    .in_m(in_m), .in_first(in_first), .in_error(in_error), .rd_en(rd_en),
    .rd_data(rd_data), .rd_m(rd_m), .rd_valid(rd_valid), .rd_last(rd_last),
    .done(done), .count(count), .sync_error(sync_error),
    .overflow(overflow), .up_error(up_error)
  );

  // single-sample instance
  logic          s_rst = 1'b1, s_arm = 1'b0, s_nd = 1'b0, s_first = 1'b0;
  logic          s_error = 1'b0, s_rd_en = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic [MW-1:0] s_m = '0;
  logic [W-1:0]  s_rd_data;
  logic [MW-1:0] s_rd_m;
  logic          s_rd_valid, s_rd_last, s_done, s_sync_error, s_overflow, s_up_error;
  logic [1:0]    s_count;

  stream_capture #(.WIDTH(W), .MWIDTH(MW), .N_DATA(1), .LOGNDATA(1)) dut1 (
    .clk(clk), .rst(s_rst), .arm(s_arm), .in_nd(s_nd), .in_data(s_data),
    .in_m(s_m), .in_first(s_first), .in_error(s_error), .rd_en(s_rd_en),
    .rd_data(s_rd_data), .rd_m(s_rd_m), .rd_valid(s_rd_valid), .rd_last(s_rd_last),
    .done(s_done), .count(s_count), .sync_error(s_sync_error),
    .overflow(s_overflow), .up_error(s_up_error)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an armed session collects a frame in a queue; the frame
  // is complete when the queue holds N words, and reads walk the queue.
  bit                  m_active;
  bit                  m_seen_first;
  logic [W+MW-1:0]     m_frame[$];
  int                  m_rd_idx;
  bit                  e_sync, e_ovf, e_uperr, e_rv, e_rl;
  logic [W+MW-1:0]     e_word;

  task automatic model_step();
    if (rst) begin
      m_active = 0; m_seen_first = 0; m_frame.delete(); m_rd_idx = 0;
      e_sync = 0; e_ovf = 0; e_uperr = 0; e_rv = 0; e_rl = 0; e_word = '0;
    end else if (arm) begin
      m_active = 1; m_seen_first = 0; m_frame.delete(); m_rd_idx = 0;
      e_sync = 0; e_ovf = 0; e_uperr = 0; e_rv = 0; e_rl = 0;
    end else begin
      e_rv = 0; e_rl = 0;
      if (m_active) begin
        if (in_error) e_uperr = 1;
        if (m_frame.size() == N) begin
          if (in_nd) e_ovf = 1;
          if (rd_en) begin
            e_rv   = 1;
            e_word = m_frame[m_rd_idx];
            e_rl   = (m_rd_idx == N - 1);
            m_rd_idx++;
            if (e_rl) begin
              m_active = 0;
              m_frame.delete();
              m_rd_idx = 0;
            end
          end
        end else if (in_nd) begin
          if (m_seen_first) begin
            if (in_first) e_sync = 1;
            m_frame.push_back({in_m, in_data});
          end else if (in_first) begin
            m_seen_first = 1;
            m_frame.push_back({in_m, in_data});
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("rd_valid",   rd_valid,   e_rv);
    check("rd_last",    rd_last,    e_rl);
    check("rd_data",    rd_data,    e_word[W-1:0]);
    check("rd_m",       rd_m,       e_word[W+MW-1:W]);
    check("done",       done,       m_active && m_frame.size() == N);
    check("count",      count,      m_active ? m_frame.size() : 0);
    check("sync_error", sync_error, e_sync);
    check("overflow",   overflow,   e_ovf);
    check("up_error",   up_error,   e_uperr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    arm = 0; in_nd = 0; in_first = 0; in_error = 0; rd_en = 0;
    in_data = '0; in_m = '0;
  endtask

  task automatic push(input logic [W-1:0] d, input logic [MW-1:0] m, input bit f);
    in_nd = 1; in_data = d; in_m = m; in_first = f;
    tick();
    in_nd = 0; in_first = 0;
  endtask

  task automatic do_arm();
    arm = 1;
    tick();
    arm = 0;
  endtask

  task automatic send_frame(input int base, input int second_first);
    for (int i = 0; i < N; i++)
      push(W'(base + i), MW'(i == 0), (i == 0) || (i == second_first));
  endtask

  task automatic read_all();
    rd_en = 1;
    repeat (N) tick();
    rd_en = 0;
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();

    // nominal frame 0..15
    do_arm();
    send_frame(0, -1);
    read_all();

    // samples before first are discarded
    do_arm();
    push(W'(32'hA), '0, 0);
    push(W'(32'hB), '0, 0);
    push(W'(32'hC), '0, 0);
    send_frame(100, -1);
    read_all();

    // first asserted again at index 5
    do_arm();
    send_frame(200, 5);
    read_all();

    // overflow after done, then reads while idle
    do_arm();
    send_frame(300, -1);
    push(W'(32'h1111), '1, 0);
    push(W'(32'h2222), '0, 1);
    read_all();
    rd_en = 1; tick(); rd_en = 0; tick();
    rd_en = 1; tick(); tick(); rd_en = 0; tick();

    // abort after 7 samples
    do_arm();
    for (int i = 0; i < 7; i++) push(W'(400 + i), '0, i == 0);
    do_arm();
    send_frame(500, -1);
    read_all();

    // reset in the middle of readout
    do_arm();
    send_frame(600, -1);
    rd_en = 1;
    repeat (4) tick();
    rst = 1;
    tick();
    rst = 0;
    rd_en = 0;
    tick();

    // upstream error during capture
    do_arm();
    for (int i = 0; i < 3; i++) push(W'(700 + i), '0, i == 0);
    in_error = 1; tick(); in_error = 0;
    for (int i = 3; i < N; i++) push(W'(700 + i), '0, 0);
    read_all();

    // random traffic with gaps, aborts and occasional reset
    for (int c = 0; c < 4000; c++) begin
      idle_inputs();
      rst      = ($urandom_range(999) == 0);
      arm      = m_active ? ($urandom_range(299) == 0) : ($urandom_range(9) == 0);
      in_nd    = $urandom_range(1);
      in_data  = $urandom;
      in_m     = MW'($urandom_range(1));
      in_first = ($urandom_range(7) == 0);
      in_error = ($urandom_range(99) == 0);
      rd_en    = ($urandom_range(9) < 6);
      tick();
    end
    idle_inputs();
    rst = 0;
    tick();

    // single-sample frame instance
    s_rst = 1; tick();
    check("n1_reset_done",  s_done,     0);
    check("n1_reset_count", s_count,    0);
    check("n1_reset_valid", s_rd_valid, 0);
    s_rst = 0; s_arm = 1; tick(); s_arm = 0;
    s_nd = 1; s_first = 0; s_data = 32'h5555_5555; tick();
    check("n1_nofirst_done",  s_done,  0);
    check("n1_nofirst_count", s_count, 0);
    s_first = 1; s_data = 32'hDEAD_BEEF; s_m = 1; tick();
    s_nd = 0; s_first = 0; s_m = 0;
    check("n1_done",  s_done,  1);
    check("n1_count", s_count, 1);
    s_rd_en = 1; tick(); s_rd_en = 0;
    check("n1_rd_valid", s_rd_valid, 1);
    check("n1_rd_last",  s_rd_last,  1);
    check("n1_rd_data",  s_rd_data,  32'hDEAD_BEEF);
    check("n1_rd_m",     s_rd_m,     1);
    check("n1_done_clr", s_done,     0);
    check("n1_count_clr", s_count,   0);
    tick();
    check("n1_valid_drop", s_rd_valid, 0);
    check("n1_data_hold",  s_rd_data,  32'hDEAD_BEEF);
    check("n1_flags", {s_sync_error, s_overflow, s_up_error}, 3'b000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_capture.md
Name: stream_capture

Overview:
- Downstream sink for the `data_source` stream (`nd`/`data`/`m`/`first`/`error`).
- Once armed, it captures one frame of N_DATA samples, starting at the sample flagged `first`, into an internal buffer.
- It checks framing and flags errors, then plays the frame back through a simple read handshake so a bench or host can verify it.
- Intended for loopback tests and as the sink in data_source chains.

Parameters:
WIDTH, 32, sample data width
MWIDTH, 1, metadata width stored alongside each sample
N_DATA, 16, samples per captured frame (>=1)
LOGNDATA, 4, address width, ceil(log2(N_DATA)), minimum 1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
arm  in  1  single-cycle pulse: abort any activity, clear flags, wait for next first
in_nd  in  1  input sample valid
in_data  in  WIDTH  input sample
in_m  in  MWIDTH  input metadata
in_first  in  1  marks first sample of a frame (qualified by in_nd)
in_error  in  1  upstream error flag, sampled every cycle
rd_en  in  1  request next stored sample
rd_data  out  WIDTH  readback sample
rd_m  out  MWIDTH  readback metadata
rd_valid  out  1  rd_data/rd_m valid this cycle
rd_last  out  1  with rd_valid: final sample of frame
done  out  1  frame fully captured, readback available
count  out  LOGNDATA+1  samples stored in current frame
sync_error  out  1  sticky: in_first seen mid-frame
overflow  out  1  sticky: in_nd arrived while buffer full
up_error  out  1  sticky: in_error seen while ARMED/CAPTURE/FULL

Behaviour:
- Reset, when rst=1 at a clock edge:
  - state=IDLE.
  - All outputs 0: rd_data, rd_m, rd_valid, rd_last, done, count, sync_error, overflow, up_error.
  - Write and read addresses = 0.
  - rst overrides arm and all other inputs, including mid-capture or mid-readout.
- States are IDLE, ARMED, CAPTURE, FULL.
- arm=1, any state:
  - Next state=ARMED.
  - count, addresses and all sticky flags cleared; done=0.
  - in_nd in the same cycle is ignored.
- IDLE:
  - in_nd and rd_en are ignored; no flags are set.
- ARMED:
  - in_nd without in_first is discarded with no error.
  - in_nd with in_first writes the sample (data and m) to addr 0 and sets count=1.
  - Next state is CAPTURE, or FULL if N_DATA=1.
- CAPTURE:
  - Each in_nd writes at addr=count, then count increments.
  - in_first=1 here (stored sample's index ≠0) sets sync_error; the sample is still stored and the frame is not restarted.
  - The write that makes count=N_DATA moves the state to FULL, with done=1 in the same edge.
  - Gaps between in_nd of any length are allowed.
- FULL:
  - done=1 and count=N_DATA.
  - in_nd sets overflow; the sample is dropped and the buffer is unchanged.
  - rd_en=1: next edge drives rd_data/rd_m from the buffer at read addr, rd_valid=1, read addr++. Latency is one cycle.
  - rd_last=1 with the sample at addr N_DATA-1.
  - On that edge: state→IDLE, done=0, count=0. Sticky flags hold until the next arm or rst.
  - rd_en=0 gives rd_valid=0 next cycle; rd_data holds its last value.
  - rd_en is accepted every cycle, so back-to-back reads give one sample per clock.
- rd_en outside FULL is ignored; rd_valid stays 0.
- in_error=1 in ARMED, CAPTURE or FULL sets up_error.
- Buffer is N_DATA x (WIDTH+MWIDTH):
  - Single write port, single registered read port.
  - Inferable as block RAM; no reset of contents.
- No arithmetic is applied to data; count width is LOGNDATA+1 so it can represent N_DATA.

Test Plan:
- Defaults:
  - Stimulus: arm, then 16 in_nd with data 0..15, first on data 0, m=1 on data 0 only.
  - Response: done rises on the edge of the 16th write, count=16.
  - Readout with rd_en held gives rd_data 0..15 one per cycle, rd_m=1 only on sample 0, rd_last on 15.
  - Afterwards: state IDLE, done=0, all flags 0.
- Pre-first discard:
  - Stimulus: arm; 3 samples (0xA,0xB,0xC) without first; then frame 100..115 with first on 100.
  - Response: readback is 100..115; no flags set.
- Mid-frame first:
  - Stimulus: first asserted again on sample index 5.
  - Response: sync_error=1 sticky; all 16 samples read back unchanged.
- Overflow and ignored reads:
  - Stimulus: after done, 2 extra in_nd; pulse rd_en while in IDLE before arming.
  - Response: overflow=1; buffer contents intact; rd_valid never asserts in IDLE.
- Abort and reset mid-operation:
  - arm after 7 captured samples gives count=0 and ARMED; the next frame captures cleanly.
  - rst asserted mid-readout (sample 4) gives rd_valid=0 and done=0 next cycle, and every output is 0.
- Upstream error and N_DATA=1:
  - in_error pulsed for one cycle during CAPTURE gives up_error=1.
  - Rerun with N_DATA=1, LOGNDATA=1: the single first sample gives done on the same edge, and one read returns rd_valid=1 with rd_last=1.
